// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS CPU front end.
//   - opcode constants for the instruction classes the decoder recognises
//   - fetch FSM state encoding
//   - next-PC source select encoding
//   - branchOffset(): sign-extended, word-scaled branch displacement
package mips_pkg;

  localparam int PC_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } fetchState_t;

  typedef enum logic [1:0] {
    NPC_SEQ,
    NPC_BR,
    NPC_JMP
  } npcSel_t;

  // Branch immediate is a signed word count; turn it into a byte offset.
  function automatic logic [PC_W-1:0] branchOffset(input logic [15:0] imm);
    return {{(PC_W-18){imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: combinational next-PC selection.
// Ports:
//   pc      in  32  address of the current instruction
//   instr   in  32  current instruction word (jump target / branch immediate)
//   branch  in  1   decoder branch flag
//   jump    in  1   decoder jump flag (wins over branch)
//   zero    in  1   ALU zero flag, qualifies a branch
//   pcPlus4 out 32  pc + 4, modulo 2^32
//   nextPc  out 32  selected successor address
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [PC_W-1:0] pc,
  input  logic [31:0]     instr,
  input  logic            branch,
  input  logic            jump,
  input  logic            zero,
  output logic [PC_W-1:0] pcPlus4,
  output logic [PC_W-1:0] nextPc
);

  npcSel_t npcSel;

  // The opcode field plays no part in address selection; the decoder has
  // already turned it into the branch/jump flags.
  logic unusedOpcodeBits;
  assign unusedOpcodeBits = ^instr[31:26];

  assign pcPlus4 = pc + 32'd4;

  always_comb begin
    if (jump)                npcSel = NPC_JMP;
    else if (branch && zero) npcSel = NPC_BR;
    else                     npcSel = NPC_SEQ;
  end

  // Jump keeps the 256 MB region of the delay-slot address (pcPlus4), not of pc.
  always_comb begin
    unique case (npcSel)
      NPC_JMP: nextPc = {pcPlus4[31:28], instr[25:0], 2'b00};
      NPC_BR:  nextPc = pcPlus4 + branchOffset(instr[15:0]);
      default: nextPc = pcPlus4;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch stage. Holds the PC, reads instruction
// memory over a req/ack handshake, presents the fetched word to the decoder,
// advances the PC on completion and counts retired instructions.
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   imemReq/imemAddr     read request and address (address == pc)
//   imemAck/imemData     memory response, data valid with ack
//   instr/opCode         held instruction word and its [31:26] field
//   instrValid           instr/opCode valid for execute
//   instrDone            execute finished the current instruction
//   branch/jump/zero     PC-redirect inputs, used only with instrDone in HOLD
//   pc/pcPlus4           current instruction address and pc + 4
//   retired              completed-instruction count, wraps mod 2^32
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imemReq,
  output logic [ADDR_W-1:0] imemAddr,
  input  logic              imemAck,
  input  logic [31:0]       imemData,
  output logic [31:0]       instr,
  output logic [5:0]        opCode,
  output logic              instrValid,
  input  logic              instrDone,
  input  logic              branch,
  input  logic              jump,
  input  logic              zero,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pcPlus4,
  output logic [31:0]       retired
);

  fetchState_t       state;
  fetchState_t       stateNext;
  logic              loadInstr;
  logic              retire;
  logic [ADDR_W-1:0] nextPc;

  next_pc_calc uNextPc (
    .pc      (pc),
    .instr   (instr),
    .branch  (branch),
    .jump    (jump),
    .zero    (zero),
    .pcPlus4 (pcPlus4),
    .nextPc  (nextPc)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    stateNext = state;
    imemReq   = 1'b0;
    loadInstr = 1'b0;
    retire    = 1'b0;
    unique case (state)
      IDLE: stateNext = FETCH;
      FETCH: begin
        imemReq = 1'b1;
        if (imemAck) begin
          loadInstr = 1'b1;
          stateNext = HOLD;
        end
      end
      HOLD: begin
        if (instrDone) begin
          retire    = 1'b1;
          stateNext = FETCH;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: reset is sampled on the clock edge and has priority over every
  // update, so an ack or done coinciding with reset is simply dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_PC;
      instr      <= '0;
      instrValid <= 1'b0;
      retired    <= '0;
    end else begin
      if (loadInstr) begin
        instr      <= imemData;
        instrValid <= 1'b1;
      end
      if (retire) begin
        pc         <= nextPc;
        retired    <= retired + 32'd1;
        instrValid <= 1'b0;
      end
    end
  end

  assign imemAddr = pc;
  assign opCode   = instr[31:26];

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch stage of the MIPS CPU; sits directly upstream of the main control decoder.
- Holds the PC and reads instruction memory over a req/ack handshake. Presents the fetched word and its opCode field to the decoder.
- Takes branch/jump/zero resolution back from the decoder and ALU to select the next PC.
- Counts retired instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, PC/address width; fixed at 32 for this CPU.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- imemReq  out  1  instruction-memory read request
- imemAddr  out  32  read address (equals pc)
- imemAck  in  1  memory returns data this cycle
- imemData  in  32  instruction word, valid when imemAck=1
- instr  out  32  held instruction word
- opCode  out  6  instr[31:26], feeds decoder opCode
- instrValid  out  1  instr/opCode valid for execute
- instrDone  in  1  execute finished current instruction this cycle
- branch  in  1  decoder branch flag, sampled with instrDone
- jump  in  1  decoder jump flag, sampled with instrDone
- zero  in  1  ALU zero flag, sampled with instrDone
- pc  out  32  address of current instruction
- pcPlus4  out  32  pc+4, combinational
- retired  out  32  count of completed instructions

Behaviour:
- Reset values:
  - state=IDLE, pc=RESET_PC, instr=0, instrValid=0, imemReq=0, retired=0.
  - Reset mid-fetch or mid-hold aborts the in-flight request.
- States:
  - IDLE:
    - Outputs idle.
    - Next cycle goes to FETCH unconditionally.
    - imemAck ignored.
  - FETCH:
    - imemReq=1, imemAddr=pc; both held stable until imemAck.
    - imemAck=1 in the same cycle as imemReq is legal.
    - On imemAck: instr<=imemData, instrValid<=1, go to HOLD.
  - HOLD:
    - imemReq=0; instr and instrValid held.
    - On instrDone=1:
      - pc<=next PC.
      - retired<=retired+1, wrapping mod 2^32.
      - instrValid<=0; go to FETCH.
- Next PC priority, evaluated only in HOLD with instrDone=1:
  - jump=1 → {pcPlus4[31:28], instr[25:0], 2'b00}; jump wins if branch is also 1.
  - else branch=1 and zero=1 → pcPlus4 + (signext(instr[15:0]) << 2).
  - else → pcPlus4.
- Arithmetic: all PC adds are 32-bit modulo, so 32'hFFFF_FFFC + 4 = 0. Negative branch offsets wrap correctly.
- Ignored inputs:
  - instrDone outside HOLD.
  - imemAck outside FETCH.
  - branch/jump/zero unless instrDone=1 in HOLD.
- Throughput: minimum 2 cycles per instruction (ack in FETCH cycle, done in first HOLD cycle).
- No latching of stale ack: an ack arriving in the cycle reset is high is discarded.

Decomposition:
- Package mips_pkg:
  - opcode constants (R-type 6'b000000, J 6'b000010, BEQ 6'b000100, LW 6'b100011, SW 6'b101011);
  - fetch state enum {IDLE, FETCH, HOLD};
  - next-PC select enum {NPC_SEQ, NPC_BR, NPC_JMP}.
- One combinational sub-module, next_pc_calc:
  - inputs pc, instr, branch, jump, zero;
  - outputs pcPlus4, nextPc.
- The FSM, PC register and retired counter stay in pc_fetch_unit.

Test Plan:
- Reset then idle: reset high 2 cycles with imemAck=1 → imemReq=0, pc=0, retired=0. imemReq rises 2 cycles after reset deasserts (IDLE, then FETCH).
- Sequential fetch with ack delayed 3 cycles:
  - imemReq and imemAddr=0 held stable for 3 cycles.
  - Ack with 32'h8C01_0004 → instr=8C010004, opCode=6'b100011, instrValid=1.
  - instrDone → pc=4, retired=1.
- Branch taken backward:
  - pc=0x10, instr=32'h1000_FFFD, branch=1, zero=1, instrDone → pc=0x14+(-3<<2)=0x08.
  - Same with zero=0 → pc=0x14.
- Jump with jump and branch both high:
  - pc=0x4000_0000, instr=32'h0800_0010, jump=1, branch=1, zero=1 → pc=0x4000_0040.
- Boundaries:
  - pc=32'hFFFF_FFFC, plain instruction done → pc=0.
  - retired preloaded to 32'hFFFF_FFFF via repeated done → wraps to 0.
  - instrDone pulsed while in FETCH → no pc or retired change.
- Reset mid-operation:
  - Assert reset during FETCH with imemAck=1 same cycle → instrValid stays 0, pc=RESET_PC.
  - Assert reset during HOLD → instrValid=0 next cycle, retired=0.
